// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between uart_rx and the bus, with a level irq and ack handshake.
// Optional UART_RX_FIFO_WATERMARK_EN: irq triggers on count >= WATERMARK instead of non-empty.
module uart_rx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned WATERMARK = 4
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_wr_valid,
  input  logic [7:0]        I_wr_data,
  input  logic              I_rd,
  output logic [7:0]        O_rd_data,
  output logic              O_empty,
  output logic              O_full,
  output logic [ADDR_W:0]   O_count,
  output logic              O_overflow,
  input  logic              I_clr_overflow,
  output logic              O_irq,
  input  logic              I_irq_ack,
  output logic [7:0]        O_irq_id
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WM_CNT   = CNT_W'(WATERMARK);
`ifdef UART_RX_FIFO_WATERMARK_EN
  localparam bit WM_EN = 1'b1;
`else
  localparam bit WM_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              irq_q, irq_d;
  logic [7:0]        irq_id_q, irq_id_d;
  irq_state_e        state_q, state_d;
  logic              push, pop, trigger;

  // Datapath and irq next-state; trigger looks at the post-edge fill level
  always_comb begin
    pop        = I_rd && (count_q != '0);
    push       = I_wr_valid && ((count_q != FULL_CNT) || pop);
    wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (I_clr_overflow) overflow_d = 1'b0;
    if (I_wr_valid && !push) overflow_d = 1'b1;

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
    trigger = WM_EN ? (count_d >= WM_CNT) : (count_d != '0);

    unique case (state_q)
      IDLE: begin
        if (trigger) state_d = PENDING;
      end
      PENDING: begin
        if (!trigger)       state_d = IDLE;
        else if (I_irq_ack) state_d = SERVICE;
      end
      SERVICE: begin
        if (pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    irq_d    = (state_d == PENDING);
    irq_id_d = irq_d ? 8'd1 : 8'd0;
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      irq_id_q   <= 8'd0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      state_q    <= state_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge I_clk) begin
    if (push) mem_q[wr_ptr_q] <= I_wr_data;
  end

  assign O_rd_data  = mem_q[rd_ptr_q];
  assign O_empty    = empty_q;
  assign O_full     = full_q;
  assign O_count    = count_q;
  assign O_overflow = overflow_q;
  assign O_irq      = irq_q;
  assign O_irq_id   = irq_id_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, corner sequences, random vs queue model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int WM    = 4;

  logic       clk, rst_n;
  logic       wr_valid, rd, clr_ovf, irq_ack;
  logic [7:0] wr_data;
  logic [7:0] rd_data, irq_id;
  logic       empty, full, overflow, irq;
  logic [4:0] count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit m_ovf, m_irq, m_svc;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .WATERMARK(4)) dut (
    .I_clk(clk), .I_reset_n(rst_n),
    .I_wr_valid(wr_valid), .I_wr_data(wr_data), .I_rd(rd),
    .O_rd_data(rd_data), .O_empty(empty), .O_full(full), .O_count(count),
    .O_overflow(overflow), .I_clr_overflow(clr_ovf),
    .O_irq(irq), .I_irq_ack(irq_ack), .O_irq_id(irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_trigger();
`ifdef UART_RX_FIFO_WATERMARK_EN
    return mq.size() >= WM;
`else
    return mq.size() != 0;
`endif
  endfunction

  // Model reacts to one clock edge with the given inputs
  task automatic model_edge(input bit wv, input logic [7:0] wd, input bit r, input bit c, input bit a);
    bit pop_ok, push_ok;
    pop_ok  = r && (mq.size() > 0);
    push_ok = wv && ((mq.size() < DEPTH) || pop_ok);
    if (pop_ok) void'(mq.pop_front());
    if (push_ok) mq.push_back(wd);
    if (wv && !push_ok) m_ovf = 1'b1;
    else if (c)         m_ovf = 1'b0;
    if (m_svc) begin
      if (pop_ok) m_svc = 1'b0;
      m_irq = 1'b0;
    end else if (m_irq) begin
      if (!model_trigger()) m_irq = 1'b0;
      else if (a) begin
        m_irq = 1'b0;
        m_svc = 1'b1;
      end
    end else begin
      m_irq = model_trigger();
    end
  endtask

  // Called at a negedge; applies inputs across one posedge, returns at next negedge
  task automatic cyc(input bit wv, input logic [7:0] wd, input bit r, input bit c, input bit a);
    wr_valid = wv; wr_data = wd; rd = r; clr_ovf = c; irq_ack = a;
    @(posedge clk);
    model_edge(wv, wd, r, c, a);
    @(negedge clk);
    wr_valid = 1'b0; rd = 1'b0; clr_ovf = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0; m_irq = 1'b0; m_svc = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(mq.size() == DEPTH));
    chk({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
    chk({tag, "_irq"},   32'(irq), 32'(m_irq));
    chk({tag, "_irqid"}, 32'(irq_id), m_irq ? 32'd1 : 32'd0);
    if (mq.size() > 0) chk({tag, "_data"}, 32'(rd_data), 32'(mq[0]));
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    int         cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       chk_d;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    wr_valid = 1'b0; wr_data = 8'h00; rd = 1'b0; clr_ovf = 1'b0; irq_ack = 1'b0;
    rst_n = 1'b0;
    m_ovf = 1'b0; m_irq = 1'b0; m_svc = 1'b0;

    //            wv    wd     rd    clr   cnt emp   ful   ovf   chk   dat
    tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 8'h10, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
    tbl[8] = '{1'b1, 8'h20, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    @(negedge clk);
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_irq",   32'(irq), 32'd0);
    chk("rst_irqid", 32'(irq_id), 32'd0);

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].wv, tbl[i].wd, tbl[i].rd, tbl[i].clr, 1'b0);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("vec%0d_full", i),  32'(full),  32'(tbl[i].ful));
      chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(tbl[i].ovf));
      if (tbl[i].chk_d) chk($sformatf("vec%0d_data", i), 32'(rd_data), 32'(tbl[i].dat));
    end

    // Fill, overflow, set-over-clear priority, full push+pop, drain
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full",  32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_ovf",   32'(overflow), 32'd0);
    cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    chk("drop_ovf",   32'(overflow), 32'd1);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_head",  32'(rd_data), 32'h00);
    cyc(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("setprio_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", 32'(count), 32'd16);
    chk("fullpp_ovf",   32'(overflow), 32'd0);
    chk("fullpp_full",  32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(rd_data), (i < 15) ? 32'(i + 1) : 32'h55);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

`ifndef UART_RX_FIFO_WATERMARK_EN
    // Irq handshake: raise, ack, service pop, re-arm two cycles after the pop, drain in PENDING
    do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("idle_ack_irq", 32'(irq), 32'd0);
    cyc(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
    chk("push_irq",   32'(irq), 32'd1);
    chk("push_irqid", 32'(irq_id), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ack_irq",   32'(irq), 32'd0);
    chk("ack_irqid", 32'(irq_id), 32'd0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    chk("svc_push_irq", 32'(irq), 32'd0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("svc_pop_irq",  32'(irq), 32'd0);
    chk("svc_pop_data", 32'(rd_data), 32'h11);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rearm_irq",   32'(irq), 32'd1);
    chk("rearm_irqid", 32'(irq_id), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("pend_drain_irq", 32'(irq), 32'd0);
    chk("pend_drain_empty", 32'(empty), 32'd1);
`else
    // Watermark trigger: irq only at count >= 4, drops when a pop goes below it
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
      chk($sformatf("wm_push%0d_irq", i + 1), 32'(irq), 32'd0);
    end
    cyc(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    chk("wm_push4_irq", 32'(irq), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wm_pop_irq",   32'(irq), 32'd0);
    chk("wm_pop_count", 32'(count), 32'd3);
`endif

    // Asynchronous reset between edges clears outputs immediately
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_irq",   32'(irq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_irq",   32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0; m_irq = 1'b0; m_svc = 1'b0;
    @(negedge clk);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_irq",   32'(irq), 32'd0);

    // Randomized traffic against the queue model, with varied push/pop balance
    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 70 : (ph == 1) ? 30 : (ph == 2) ? 50 : 90;
      pr = (ph == 0) ? 30 : (ph == 1) ? 70 : (ph == 2) ? 50 : 10;
      for (int n = 0; n < 600; n++) begin
        bit wv, r, c, a;
        logic [7:0] wd;
        wv = ($urandom_range(99) < pw);
        r  = ($urandom_range(99) < pr);
        c  = ($urandom_range(99) < 5);
        a  = ($urandom_range(99) < 20);
        wd = 8'($urandom);
        cyc(wv, wd, r, c, a);
        check_model($sformatf("rnd%0d", ph));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer between uart_rx and the system bus/interrupt logic.
- Captures each byte uart_rx delivers and holds it until the CPU reads the UART data register.
- Raises a level interrupt while data is waiting and handshakes with the core's irq acknowledge.
- Replaces the single rx_data holding register, so back-to-back received bytes are not lost.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- WATERMARK, 4, fill level that raises the irq when UART_RX_FIFO_WATERMARK_EN is defined; valid range 1..DEPTH.

Ports:
- I_clk  in  1  system clock; all state changes on the rising edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_wr_valid  in  1  one-cycle strobe from uart_rx O_data_ready.
- I_wr_data  in  8  received byte, sampled when I_wr_valid=1.
- I_rd  in  1  one-cycle pop strobe, issued when the system completes a read of UART_1_RW.
- O_rd_data  out  8  head byte, show-ahead; valid when O_empty=0.
- O_empty  out  1  FIFO holds no bytes.
- O_full  out  1  FIFO holds DEPTH bytes.
- O_count  out  ADDR_W+1  current fill level, 0..DEPTH.
- O_overflow  out  1  sticky flag: a byte was dropped.
- I_clr_overflow  in  1  one-cycle strobe that clears O_overflow.
- O_irq  out  1  interrupt request level to the core's I_irq_active.
- I_irq_ack  in  1  one-cycle acknowledge from the core's O_irq_ack.
- O_irq_id  out  8  constant 8'd1 while O_irq=1, otherwise 0.

Behaviour:
- Reset (I_reset_n=0, asynchronous):
  - wr_ptr, rd_ptr and count clear to 0.
  - O_empty=1, O_full=0, O_overflow=0, O_irq=0, O_irq_id=0, irq FSM=IDLE.
  - Storage array is not cleared; O_rd_data is don't-care while empty.
  - Reset mid-operation discards all buffered bytes and any pending irq.
- Push: at an edge with I_wr_valid=1 and not full:
  - mem[wr_ptr] <= I_wr_data, wr_ptr+1, count+1.
  - The byte is visible on O_rd_data and O_empty=0 immediately after that edge (one-cycle write-to-read latency).
- Push while full:
  - Byte dropped; O_overflow <= 1; pointers and count unchanged.
- Pop: at an edge with I_rd=1 and not empty:
  - rd_ptr+1, count-1; O_rd_data shows the next entry after that edge.
- Pop while empty: ignored, no state change.
- Simultaneous push and pop:
  - Non-empty, non-full: both take effect; count unchanged.
  - Full: both take effect (the pop frees the slot); no overflow.
  - Empty: push only; the pop is ignored.
- Pointers wrap modulo DEPTH (natural ADDR_W-bit overflow).
- O_full = (count==DEPTH); O_empty = (count==0); both derive from the registered count, not from a pointer compare.
- O_overflow:
  - Set has priority over I_clr_overflow in the same cycle.
  - Otherwise I_clr_overflow clears it.
- Irq FSM, states IDLE, PENDING, SERVICE. trigger = !O_empty (base build).
  - IDLE: trigger → PENDING; O_irq goes 1 the cycle after the push edge.
  - PENDING: O_irq=1, O_irq_id=1. I_irq_ack → SERVICE, O_irq=0.
  - SERVICE: O_irq=0. Accepted pop → IDLE. Re-arming is evaluated the next cycle, so a still-non-empty FIFO re-raises O_irq two cycles after the pop edge.
  - An ack in IDLE or SERVICE is ignored.
  - If the FIFO drains by pops while in PENDING, return to IDLE and deassert O_irq.

Optional Feature:
- Macro: UART_RX_FIFO_WATERMARK_EN.
- Defined:
  - trigger = (count >= WATERMARK).
  - PENDING falls back to IDLE when count drops below WATERMARK before the ack.
  - SERVICE exits on the first pop as in the base build.
- Not defined: trigger = !O_empty; the WATERMARK parameter is ignored.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on separate cycles → O_count=3, O_rd_data=0x41. Pop three times → reads 0x41, 0x42, 0x43; then O_empty=1, O_count=0.
- Push 17 bytes 0x00..0x10 with DEPTH=16 → O_full=1 after the 16th push, 0x10 dropped, O_overflow=1. Pulse I_clr_overflow → O_overflow=0. Drain → 0x00..0x0F in order.
- Full FIFO with push 0x55 and pop in the same cycle → O_count stays 16, O_overflow=0, 0x55 read last. Empty FIFO with push and pop in the same cycle → O_count=1.
- Push 0x7E → O_irq=1 and O_irq_id=1 next cycle. Pulse I_irq_ack → O_irq=0. Push another byte, then pop → O_irq returns to 1 two cycles after the pop.
- Fill 5 bytes, assert I_reset_n=0 between clock edges → outputs clear immediately. After release, O_empty=1 and O_irq=0.
- With UART_RX_FIFO_WATERMARK_EN and WATERMARK=4 → pushes 1-3 leave O_irq=0, push 4 raises O_irq. A pop before the ack (count=3) drops O_irq.
